btn_fifo_ctrl: RTL and testbench
================================

# btn_fifo_ctrl

Single-clock, parametrised button-driven FIFO controller: next generation of the switch/button FIFO board design. Samples active-low push/pop buttons, turns each press into exactly one FIFO operation, stores `sw` words, and exposes the last popped word plus occupancy and sticky error status for the board top to map onto LEDs. The divided write/read clocks are gone: everything runs on `clk`.

## Interface
- `WIDTH`, 4: data word width (≥1).
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `DEBOUNCE_CYCLES`, 500000: stable-level cycles required before a button change is accepted (≥2; only used with `BTN_FIFO_DEBOUNCE_EN`).

Ports:
- `clk` in 1: system clock, 100 MHz.
- `reset_btn` in 1: asynchronous, active-low reset.
- `push_btn` in 1: active-low push button, asynchronous to `clk`.
- `pop_btn` in 1: active-low pop button, asynchronous to `clk`.
- `sw` in WIDTH: data written on push.
- `dout` out WIDTH: last successfully popped word, registered.
- `count` out $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- `full` out 1: count == DEPTH.
- `empty` out 1: count == 0.
- `overflow` out 1: sticky; a push was rejected because the FIFO was full.
- `underflow` out 1: sticky; a pop was rejected because the FIFO was empty.

## Operation
- Button path (per button): 2-flop synchroniser → optional debouncer → falling-edge detector → one-cycle `push_req` / `pop_req`.
- All button-path registers reset to 0 ("pressed"). A button held through reset release generates no event. Releasing a button generates no event. A held button generates exactly one event.
- Push: if `!full`, write `sw` to `mem[wr_ptr]` and increment `wr_ptr` modulo DEPTH. If `full`, no write and set `overflow`.
- Pop: if `!empty`, `dout <= mem[rd_ptr]` and increment `rd_ptr` modulo DEPTH. If `empty`, `dout` holds and set `underflow`.
- Simultaneous push_req and pop_req are judged on pre-cycle state:
  - neither full nor empty: both occur, count unchanged;
  - full: pop reads the oldest word, push writes the freed slot, count stays DEPTH, no overflow;
  - empty: push occurs, pop rejected, `underflow` set, count becomes 1.
- `count`: +1 on push only, −1 on pop only. `full`/`empty` are registered and consistent with `count` every cycle.
- `overflow`/`underflow` clear only on reset.
- Reset values: pointers 0, `count` 0, `empty` 1, `full` 0, `dout` 0, `overflow` 0, `underflow` 0. Memory contents are not reset. Reset asserted mid-operation clears everything immediately; pending requests are lost.

## Timing
- Without debounce: button first sampled low at edge k → sync output low after edge k+1 → request pulse during cycle k+1..k+2 → `count`/`full`/`empty`/`dout`/flags update at edge k+2.
- With debounce: the debounced level changes after the sync output has differed from it for DEBOUNCE_CYCLES consecutive cycles. Any bounce restarts the count. This adds DEBOUNCE_CYCLES cycles to the latency above.
- Minimum spacing between accepted presses of one button: 2 cycles (press and release) without debounce; 2×DEBOUNCE_CYCLES with it.

## Configuration
- `BTN_FIFO_DEBOUNCE_EN` defined: each button passes through a debounce counter of $clog2(DEBOUNCE_CYCLES) bits.
- Undefined: synchroniser output feeds the edge detector directly; `DEBOUNCE_CYCLES` is ignored and no counter logic is generated.

## Structure
- Package `btn_fifo_pkg`:
  - pointer and count width helper functions;
  - default `WIDTH`/`DEPTH`/`DEBOUNCE_CYCLES` constants;
  - button reset level constant (0).
- Sub-module `btn_debounce` (synchroniser + optional debounce + falling-edge pulse), instantiated twice.
- FIFO storage and pointers stay in `btn_fifo_ctrl`.

## Test plan
Benches run at WIDTH=4, DEPTH=8, DEBOUNCE_CYCLES=4.
- Reset, push 8 presses with `sw`=1..8 → `count` steps 1..8; `full`=1 after the 8th press; `overflow`=0.
- 9th push with `sw`=9 → `count`=8, `overflow`=1; a later pop returns `dout`=1 (the 9 was not stored).
- 8 pops → `dout` sequence 1..8, `empty`=1; a 9th pop → `underflow`=1, `dout` stays 8.
- Push 3, pop 3 with values A, B, C, repeated 4 times → pointer wrap, FIFO order preserved, `count` returns to 0.
- Push and pop requests in the same cycle at count 0, 3 and 8 → resulting count 1 (`underflow`=1), 3, 8; `dout` is the oldest word.
- Debounce enabled: push_btn toggles every 2 cycles for 20 cycles, then held low → exactly one push. Push held low across reset release → no push.

Source files
------------

// File: rtl/btn_fifo_pkg.sv
// -----------------------------------------------------------------------------
// btn_fifo_pkg
//
// Shared definitions for the button-driven FIFO controller:
//   - default WIDTH / DEPTH / DEBOUNCE_CYCLES values
//   - reset level of every button-path register (0 = "pressed")
//   - width helpers for the FIFO pointers and the occupancy counter
//
// Optional feature macro used by the design: BTN_FIFO_DEBOUNCE_EN
// -----------------------------------------------------------------------------
package btn_fifo_pkg;

  localparam int DEF_WIDTH           = 4;
  localparam int DEF_DEPTH           = 8;
  localparam int DEF_DEBOUNCE_CYCLES = 500000;

  // Button-path registers come out of reset reading "pressed". A button held
  // through reset release then looks unchanged, so no falling edge is seen.
  localparam logic BTN_RESET_LEVEL = 1'b0;

  // Pointer width for a power-of-two FIFO; pointers wrap naturally.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Occupancy needs one extra bit to represent the value DEPTH itself.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage : btn_fifo_pkg

// File: rtl/btn_fifo_ctrl_btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
//
// Turns one raw, asynchronous, active-low button into a single-cycle request
// pulse per press:
//   2-flop synchroniser -> optional debouncer -> falling-edge detector.
//
// Configuration macro: BTN_FIFO_DEBOUNCE_EN
//   defined   : the synchronised level must differ from the accepted level for
//               DEBOUNCE_CYCLES consecutive cycles before it is accepted; any
//               bounce restarts the count.
//   undefined : the synchroniser output feeds the edge detector directly and
//               no counter logic exists.
//
// Ports:
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset
//   btn    in  raw active-low button level (asynchronous to clk)
//   pulse  out one-cycle high on each accepted press (high -> low transition)
// -----------------------------------------------------------------------------
module btn_debounce
  import btn_fifo_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("btn_debounce: DEBOUNCE_CYCLES must be at least 2");
  end

  logic sync_q1;
  logic sync_q2;
  logic level;     // accepted button level seen by the edge detector
  logic level_q;   // accepted level one cycle earlier

  // Two-flop synchroniser for the asynchronous button input.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= BTN_RESET_LEVEL;
      sync_q2 <= BTN_RESET_LEVEL;
    end else begin
      sync_q1 <= btn;
      sync_q2 <= sync_q1;
    end
  end

`ifdef BTN_FIFO_DEBOUNCE_EN
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);

  logic [DB_W-1:0] db_cnt;
  logic            db_level;

  // db_cnt counts consecutive cycles in which the synchronised level disagrees
  // with the accepted level. On the DEBOUNCE_CYCLES-th such cycle the new
  // level is taken; a return to agreement (a bounce) clears the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt   <= '0;
      db_level <= BTN_RESET_LEVEL;
    end else if (sync_q2 == db_level) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
      db_cnt   <= '0;
      db_level <= sync_q2;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  assign level = db_level;
`else
  assign level = sync_q2;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= BTN_RESET_LEVEL;
    end else begin
      level_q <= level;
    end
  end

  // Press = released (1) last cycle, pressed (0) now. Releases and held
  // buttons produce nothing, so one press yields exactly one pulse.
  assign pulse = level_q & ~level;

endmodule : btn_debounce

// File: rtl/btn_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// btn_fifo_ctrl
//
// Single-clock FIFO driven by two active-low push buttons. Each accepted press
// of push_btn writes sw into the FIFO; each accepted press of pop_btn moves the
// oldest word to dout. Occupancy and sticky error flags are exported for LEDs.
//
// Configuration macro: BTN_FIFO_DEBOUNCE_EN (adds a DEBOUNCE_CYCLES debouncer
// to each button path inside btn_debounce; absent by default).
//
// Parameters:
//   WIDTH            data word width (>= 1)
//   DEPTH            FIFO entries, power of two (>= 2)
//   DEBOUNCE_CYCLES  stable cycles before a button change is accepted
//
// Ports:
//   clk        in   system clock
//   reset_btn  in   asynchronous active-low reset
//   push_btn   in   active-low push button (asynchronous)
//   pop_btn    in   active-low pop button (asynchronous)
//   sw         in   data written on push
//   dout       out  last successfully popped word (registered)
//   count      out  occupancy 0..DEPTH
//   full       out  count == DEPTH (registered)
//   empty      out  count == 0 (registered)
//   overflow   out  sticky: a push was rejected while full
//   underflow  out  sticky: a pop was rejected while empty
// -----------------------------------------------------------------------------
module btn_fifo_ctrl
  import btn_fifo_pkg::*;
#(
  parameter int WIDTH           = DEF_WIDTH,
  parameter int DEPTH           = DEF_DEPTH,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic                   clk,
  input  logic                   reset_btn,
  input  logic                   push_btn,
  input  logic                   pop_btn,
  input  logic [WIDTH-1:0]       sw,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = cnt_width(DEPTH);

  if (WIDTH < 1 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_params
    $error("btn_fifo_ctrl: WIDTH must be >= 1 and DEPTH a power of two >= 2");
  end

  logic rst_n;
  assign rst_n = reset_btn;

  // ---------------------------------------------------------------------------
  // Button paths
  // ---------------------------------------------------------------------------
  logic push_req;
  logic pop_req;

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_push_btn (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (push_btn),
    .pulse (push_req)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_pop_btn (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (pop_btn),
    .pulse (pop_req)
  );

  // ---------------------------------------------------------------------------
  // FIFO state
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_next;
  logic             do_push;
  logic             do_pop;

  // Requests are judged on pre-cycle state. A pop on a full FIFO frees the
  // slot the simultaneous push writes (wr_ptr == rd_ptr then; the read sees
  // the old word because both are edge-sampled). A pop on an empty FIFO is
  // rejected even when a push arrives in the same cycle.
  // NOTE: combinational logic uses blocking (=) and assigns every output a
  // default first, so no path leaves a signal unassigned and no latch appears.
  always_comb begin
    do_pop     = pop_req && !empty;
    do_push    = push_req && (!full || do_pop);
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // NOTE: storage is deliberately left out of reset so it maps onto plain
  // RAM; nothing reads an entry before it has been written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= sw;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      dout      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        dout   <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      // Flags derive from the next count so they agree with count every cycle.
      count <= count_next;
      full  <= (count_next == CNT_W'(DEPTH));
      empty <= (count_next == '0);
      // Error flags are sticky until reset.
      if (push_req && !do_push) begin
        overflow <= 1'b1;
      end
      if (pop_req && !do_pop) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule : btn_fifo_ctrl

// File: tb/tb_btn_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_btn_fifo_ctrl
//
// Directed bench for btn_fifo_ctrl at WIDTH=4, DEPTH=8, DEBOUNCE_CYCLES=4.
// A queue holds the words the FIFO should contain; pushes append the driven
// sw value, pops take the front as the expected dout.
// -----------------------------------------------------------------------------
module tb_btn_fifo_ctrl;
  import btn_fifo_pkg::*;

  localparam int W  = 4;
  localparam int D  = 8;
  localparam int DB = 4;
`ifdef BTN_FIFO_DEBOUNCE_EN
  localparam int HOLD = DB + 6;
`else
  localparam int HOLD = 6;
`endif

  logic         clk       = 1'b0;
  logic         reset_btn = 1'b0;
  logic         push_btn  = 1'b0;
  logic         pop_btn   = 1'b0;
  logic [W-1:0] sw        = '0;
  logic [W-1:0] dout;
  logic [3:0]   count;
  logic         full;
  logic         empty;
  logic         overflow;
  logic         underflow;

  btn_fifo_ctrl #(
    .WIDTH           (W),
    .DEPTH           (D),
    .DEBOUNCE_CYCLES (DB)
  ) dut (
    .clk       (clk),
    .reset_btn (reset_btn),
    .push_btn  (push_btn),
    .pop_btn   (pop_btn),
    .sw        (sw),
    .dout      (dout),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  int           n_cmp  = 0;
  int           n_fail = 0;
  logic [W-1:0] sb [$];
  logic [W-1:0] m_dout = '0;
  logic         m_ovf  = 1'b0;
  logic         m_udf  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_state(input string tag);
    check({tag, ".count"},     32'(count),     32'(sb.size()));
    check({tag, ".full"},      32'(full),      32'(sb.size() == D));
    check({tag, ".empty"},     32'(empty),     32'(sb.size() == 0));
    check({tag, ".overflow"},  32'(overflow),  32'(m_ovf));
    check({tag, ".underflow"}, 32'(underflow), 32'(m_udf));
    check({tag, ".dout"},      32'(dout),      32'(m_dout));
  endtask

  // One press (and release) of the selected buttons, then model update.
  task automatic op(input bit push, input bit pop, input logic [W-1:0] val, input string tag);
    bit pre_full;
    bit pre_empty;
    pre_full  = (sb.size() == D);
    pre_empty = (sb.size() == 0);
    sw       = val;
    push_btn = ~push;
    pop_btn  = ~pop;
    idle(HOLD);
    push_btn = 1'b1;
    pop_btn  = 1'b1;
    idle(HOLD);
    if (pop) begin
      if (!pre_empty) m_dout = sb.pop_front();
      else            m_udf  = 1'b1;
    end
    if (push) begin
      if (!pre_full || pop) sb.push_back(val);
      else                  m_ovf = 1'b1;
    end
    check_state(tag);
  endtask

  task automatic apply_reset();
    reset_btn = 1'b0;
    idle(2);
    sb.delete();
    m_dout = '0;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
    check_state("reset");
    reset_btn = 1'b1;
    idle(2);
  endtask

  initial begin
    // Reset with both buttons held; holding them through release is not a press.
    idle(3);
    check_state("por");
    reset_btn = 1'b1;
    idle(HOLD);
    check_state("held_thru_reset");
    push_btn = 1'b1;
    pop_btn  = 1'b1;
    idle(HOLD);
    check_state("release_after_reset");

    // Fill, then overflow.
    for (int i = 1; i <= 8; i++) op(1'b1, 1'b0, W'(i), $sformatf("fill%0d", i));
    op(1'b1, 1'b0, 4'd9, "push_full");

    // Drain, then underflow (dout must hold 8).
    for (int i = 1; i <= 8; i++) op(1'b0, 1'b1, '0, $sformatf("drain%0d", i));
    op(1'b0, 1'b1, '0, "pop_empty");

    apply_reset();

    // Pointer wrap: 3 in / 3 out, four times.
    for (int r = 0; r < 4; r++) begin
      op(1'b1, 1'b0, 4'hA, $sformatf("wrap%0d.pushA", r));
      op(1'b1, 1'b0, 4'hB, $sformatf("wrap%0d.pushB", r));
      op(1'b1, 1'b0, 4'hC, $sformatf("wrap%0d.pushC", r));
      op(1'b0, 1'b1, '0,   $sformatf("wrap%0d.pop1", r));
      op(1'b0, 1'b1, '0,   $sformatf("wrap%0d.pop2", r));
      op(1'b0, 1'b1, '0,   $sformatf("wrap%0d.pop3", r));
    end

    // Simultaneous push+pop at count 0, 3 and 8.
    op(1'b1, 1'b1, 4'd5, "both_at0");
    op(1'b1, 1'b0, 4'd6, "to3a");
    op(1'b1, 1'b0, 4'd7, "to3b");
    op(1'b1, 1'b1, 4'd8, "both_at3");
    for (int i = 9; i <= 13; i++) op(1'b1, 1'b0, W'(i), $sformatf("to8_%0d", i));
    op(1'b1, 1'b1, 4'd14, "both_at8");
    op(1'b0, 1'b1, '0, "after_both_pop");

    // Reset in the middle of a press: everything clears, the press is lost.
    push_btn = 1'b0;
    sw       = 4'd3;
    idle(1);
    reset_btn = 1'b0;
    idle(2);
    sb.delete();
    m_dout = '0;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
    check_state("mid_reset");
    reset_btn = 1'b1;
    idle(HOLD);
    push_btn = 1'b1;
    idle(HOLD);
    check_state("after_mid_reset");
    op(1'b1, 1'b0, 4'd4, "push_after_reset");

`ifdef BTN_FIFO_DEBOUNCE_EN
    // Bouncing push for 20 cycles, then held low: exactly one push.
    sw = 4'd11;
    for (int t = 0; t < 10; t++) begin
      push_btn = ~push_btn;
      idle(2);
    end
    push_btn = 1'b0;
    idle(HOLD);
    push_btn = 1'b1;
    idle(HOLD);
    sb.push_back(4'd11);
    check_state("bounce");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_btn_fifo_ctrl
